// File: rtl/pc11_pkg.sv
// Shared constants and state types for the PC11 paper-tape register block.
package pc11_pkg;

  localparam logic [1:0] SEL_PRS = 2'd0;
  localparam logic [1:0] SEL_PRB = 2'd1;
  localparam logic [1:0] SEL_PPS = 2'd2;
  localparam logic [1:0] SEL_PPB = 2'd3;

  localparam int unsigned BIT_ERR   = 15;
  localparam int unsigned BIT_BUSY  = 11;
  localparam int unsigned BIT_DONE  = 7;
  localparam int unsigned BIT_READY = 7;
  localparam int unsigned BIT_IE    = 6;
  localparam int unsigned BIT_ENB   = 0;

  localparam logic [7:0] VEC_RDR = 8'o070;
  localparam logic [7:0] VEC_PUN = 8'o074;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_PULSE, R_BUSY} rd_state_e;
  typedef enum logic [1:0] {P_IDLE, P_WAIT, P_PULSE, P_BUSY} pu_state_e;

endpackage

// File: rtl/pc11_irq_edge.sv
// Pending flag set on a rising edge of its level; cleared by ack or when the level drops.
module pc11_irq_edge (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_level,
  input  logic i_ack,
  output logic o_pend
);

  logic level_q, level_d;
  logic pend_q, pend_d;

  always_comb begin
    level_d = i_level;
    pend_d  = pend_q;
    // A fresh edge beats a coincident ack.
    if (i_level && !level_q) pend_d = 1'b1;
    else if (i_ack || !i_level) pend_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      pend_q  <= pend_d;
    end
  end

  assign o_pend = pend_q;

endmodule

// File: rtl/pc11_regs.sv
// PC11 paper-tape reader/punch registers: CPU register decode, SD engine command
// sequencing with a shared watchdog, and vectored reader/punch interrupts.
module pc11_regs
  import pc11_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 27_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_reg_sel,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_irq,
  output logic [7:0]  o_irq_vector,
  input  logic        i_irq_ack,
  output logic        o_tape_read,
  output logic        o_tape_punch,
  output logic        o_tape_flush,
  output logic        o_tape_clear_done,
  output logic [7:0]  o_tape_punch_data,
  input  logic        i_tape_read_busy,
  input  logic        i_tape_read_done,
  input  logic        i_tape_punch_ready,
  input  logic [7:0]  i_tape_read_data,
  input  logic [3:0]  i_sd_error
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  rd_state_e rstate_q, rstate_d;
  pu_state_e pstate_q, pstate_d;
  logic rseen_q, rseen_d, pseen_q, pseen_d, pflush_q, pflush_d;
  logic rie_q, rie_d, pie_q, pie_d, rdone_q, rdone_d, tmo_q, tmo_d;
  logic clear_done_q, clear_done_d;
  logic [7:0] pdata_q, pdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic err, rbusy, pready, tmo_hit, cnt_active;
  logic prs_wr, prb_rd, pps_wr, ppb_wr;
  logic rlevel, plevel, rpend, ppend, ack_r, ack_p;
  logic unused_wdata;

  assign unused_wdata = ^i_wdata[15:8];

  assign prs_wr = i_wr && (i_reg_sel == SEL_PRS);
  assign prb_rd = i_rd && (i_reg_sel == SEL_PRB);
  assign pps_wr = i_wr && (i_reg_sel == SEL_PPS);
  assign ppb_wr = i_wr && (i_reg_sel == SEL_PPB);

  assign err        = (i_sd_error != '0) || tmo_q;
  assign rbusy      = (rstate_q != R_IDLE);
  assign pready     = (pstate_q == P_IDLE) && i_tape_punch_ready && (rstate_q == R_IDLE);
  assign cnt_active = (rstate_q != R_IDLE) || (pstate_q != P_IDLE);
  assign tmo_hit    = (cnt_q >= CW'(TIMEOUT_CYC - 1));

  always_comb begin
    rstate_d = rstate_q;  pstate_d = pstate_q;
    rseen_d  = rseen_q;   pseen_d  = pseen_q;   pflush_d = pflush_q;
    rie_d    = rie_q;     pie_d    = pie_q;
    rdone_d  = rdone_q;   tmo_d    = tmo_q;
    clear_done_d = clear_done_q;
    pdata_d  = pdata_q;
    cnt_d    = cnt_q;

    if (cnt_active && !tmo_hit) cnt_d = cnt_q + CW'(1);

    if (prs_wr) begin
      rie_d = i_wdata[BIT_IE];
      if (i_wdata[BIT_ENB]) begin
        rdone_d = 1'b0;
        tmo_d   = 1'b0;
        if (rstate_q == R_IDLE) begin
          rstate_d = R_WAIT;
          cnt_d    = '0;
        end
      end
    end

    if (prb_rd) begin
      rdone_d      = 1'b0;
      clear_done_d = 1'b1;
    end else if (clear_done_q && !i_tape_read_done) begin
      clear_done_d = 1'b0;
    end

    if (pps_wr) begin
      pie_d = i_wdata[BIT_IE];
      if (i_wdata[BIT_ENB] && pready) begin
        pstate_d = P_WAIT;
        pflush_d = 1'b1;
        cnt_d    = '0;
      end
    end

    if (ppb_wr && pready) begin
      pdata_d  = i_wdata[7:0];
      tmo_d    = 1'b0;
      pstate_d = P_WAIT;
      pflush_d = 1'b0;
      cnt_d    = '0;
    end

    // FSM completion/timeout is evaluated last so it overrides same-cycle clears.
    case (rstate_q)
      R_WAIT: begin
        if (tmo_hit) begin
          rstate_d = R_IDLE; tmo_d = 1'b1; rdone_d = 1'b1;
        end else if (i_tape_punch_ready && (pstate_q == P_IDLE)) begin
          rstate_d = R_PULSE;
        end
      end
      R_PULSE: begin
        rstate_d = R_BUSY;
        rseen_d  = 1'b0;
      end
      R_BUSY: begin
        if (tmo_hit) begin
          rstate_d = R_IDLE; tmo_d = 1'b1; rdone_d = 1'b1;
        end else if (rseen_q && !i_tape_read_busy) begin
          rstate_d = R_IDLE; rdone_d = 1'b1;
        end else if (i_tape_read_busy) begin
          rseen_d = 1'b1;
        end
      end
      default: ;
    endcase

    case (pstate_q)
      P_WAIT: begin
        if (tmo_hit) begin
          pstate_d = P_IDLE; tmo_d = 1'b1;
        end else if (i_tape_punch_ready) begin
          pstate_d = P_PULSE;
        end
      end
      P_PULSE: begin
        pstate_d = P_BUSY;
        pseen_d  = 1'b0;
      end
      P_BUSY: begin
        if (tmo_hit) begin
          pstate_d = P_IDLE; tmo_d = 1'b1;
        end else if (pseen_q && i_tape_punch_ready) begin
          pstate_d = P_IDLE;
        end else if (!i_tape_punch_ready) begin
          pseen_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rstate_q <= R_IDLE;  pstate_q <= P_IDLE;
      rseen_q  <= 1'b0;    pseen_q  <= 1'b0;   pflush_q <= 1'b0;
      rie_q    <= 1'b0;    pie_q    <= 1'b0;
      rdone_q  <= 1'b0;    tmo_q    <= 1'b0;
      clear_done_q <= 1'b0;
      pdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rstate_q <= rstate_d;  pstate_q <= pstate_d;
      rseen_q  <= rseen_d;   pseen_q  <= pseen_d;   pflush_q <= pflush_d;
      rie_q    <= rie_d;     pie_q    <= pie_d;
      rdone_q  <= rdone_d;   tmo_q    <= tmo_d;
      clear_done_q <= clear_done_d;
      pdata_q  <= pdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg_sel)
      SEL_PRS: begin
        o_rdata[BIT_ERR]  = err;
        o_rdata[BIT_BUSY] = rbusy;
        o_rdata[BIT_DONE] = rdone_q;
        o_rdata[BIT_IE]   = rie_q;
      end
      SEL_PRB: o_rdata[7:0] = i_tape_read_data;
      SEL_PPS: begin
        o_rdata[BIT_ERR]   = err;
        o_rdata[BIT_READY] = pready;
        o_rdata[BIT_IE]    = pie_q;
      end
      default: ;
    endcase
  end

  assign rlevel = (rdone_q || err) && rie_q;
  assign plevel = pready && pie_q;
  assign ack_r  = i_irq_ack && rpend;
  assign ack_p  = i_irq_ack && !rpend && ppend;

  pc11_irq_edge u_irq_rdr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (rlevel),
    .i_ack     (ack_r),
    .o_pend    (rpend)
  );

  pc11_irq_edge u_irq_pun (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (plevel),
    .i_ack     (ack_p),
    .o_pend    (ppend)
  );

  assign o_irq             = rpend || ppend;
  assign o_irq_vector      = (ppend && !rpend) ? VEC_PUN : VEC_RDR;
  assign o_tape_read       = (rstate_q == R_PULSE);
  assign o_tape_punch      = (pstate_q == P_PULSE) && !pflush_q;
  assign o_tape_flush      = (pstate_q == P_PULSE) && pflush_q;
  assign o_tape_clear_done = clear_done_q;
  assign o_tape_punch_data = pdata_q;

endmodule

// File: tb/tb_pc11_regs.sv
// Bench for pc11_regs: reset table, directed command sequences, randomized register/irq traffic.
module tb_pc11_regs;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [1:0]  i_reg_sel = 2'd0;
  logic        i_rd = 1'b0, i_wr = 1'b0;
  logic [15:0] i_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_irq;
  logic [7:0]  o_irq_vector;
  logic        i_irq_ack = 1'b0;
  logic        o_tape_read, o_tape_punch, o_tape_flush, o_tape_clear_done;
  logic [7:0]  o_tape_punch_data;
  logic        i_tape_read_busy = 1'b0, i_tape_read_done = 1'b0, i_tape_punch_ready = 1'b1;
  logic [7:0]  i_tape_read_data = '0;
  logic [3:0]  i_sd_error = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0, n_pu = 0, n_fl = 0;

  pc11_regs #(.TIMEOUT_CYC(100)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_reg_sel(i_reg_sel), .i_rd(i_rd), .i_wr(i_wr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_irq(o_irq), .o_irq_vector(o_irq_vector),
    .i_irq_ack(i_irq_ack), .o_tape_read(o_tape_read), .o_tape_punch(o_tape_punch),
    .o_tape_flush(o_tape_flush), .o_tape_clear_done(o_tape_clear_done),
    .o_tape_punch_data(o_tape_punch_data), .i_tape_read_busy(i_tape_read_busy),
    .i_tape_read_done(i_tape_read_done), .i_tape_punch_ready(i_tape_punch_ready),
    .i_tape_read_data(i_tape_read_data), .i_sd_error(i_sd_error)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_tape_read)  n_rd++;
    if (o_tape_punch) n_pu++;
    if (o_tape_flush) n_fl++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    i_reg_sel = sel; i_wdata = data; i_wr = 1'b1;
    cyc(1);
    i_wr = 1'b0;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_rd = 1'b0; i_wr = 1'b0; i_irq_ack = 1'b0; i_reg_sel = 2'd0;
    i_tape_read_busy = 1'b0; i_tape_read_done = 1'b0; i_tape_punch_ready = 1'b1;
    i_sd_error = '0; i_tape_read_data = '0;
    cyc(2);
    i_reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_neg(input int budget, input int which);
    for (int k = 0; k < budget; k++) begin
      @(negedge i_clk);
      if (which == 0 && o_tape_read)  break;
      if (which == 1 && o_tape_punch) break;
      if (which == 2 && o_tape_flush) break;
      if (which == 3 && o_irq)        break;
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  sd;
    logic        rdy;
    logic [7:0]  rdat;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[8];

  logic        m_rie, m_pie, m_rp, m_pp, m_rl, m_pl, rl, pl, e, ar, ap;
  logic [15:0] exp_rd;
  logic [7:0]  exp_vec;
  int          c0, c1, cnt;

  initial begin
    tbl[0] = '{2'd0, 4'd0, 1'b1, 8'h00, 16'h0000};
    tbl[1] = '{2'd0, 4'd5, 1'b1, 8'h00, 16'h8000};
    tbl[2] = '{2'd1, 4'd0, 1'b1, 8'hA5, 16'h00A5};
    tbl[3] = '{2'd1, 4'd0, 1'b0, 8'h3C, 16'h003C};
    tbl[4] = '{2'd2, 4'd0, 1'b1, 8'h00, 16'h0080};
    tbl[5] = '{2'd2, 4'd0, 1'b0, 8'h00, 16'h0000};
    tbl[6] = '{2'd2, 4'd9, 1'b1, 8'h00, 16'h8080};
    tbl[7] = '{2'd3, 4'hF, 1'b1, 8'hFF, 16'h0000};

    do_reset();
    @(negedge i_clk);
    chk("rst_irq", o_irq, 0);
    chk("rst_vec", o_irq_vector, 8'o070);
    chk("rst_pulses", {o_tape_read, o_tape_punch, o_tape_flush, o_tape_clear_done}, 0);
    chk("rst_pdata", o_tape_punch_data, 0);
    for (int i = 0; i < 8; i++) begin
      i_reg_sel = tbl[i].sel; i_sd_error = tbl[i].sd;
      i_tape_punch_ready = tbl[i].rdy; i_tape_read_data = tbl[i].rdat;
      #2;
      chk($sformatf("rst_tbl%0d", i), o_rdata, tbl[i].exp);
    end
    i_sd_error = '0; i_tape_punch_ready = 1'b1; i_tape_read_data = '0;
    cyc(1);

    // Reader: enable, pulse at N+2, busy 1->0, done + interrupt, ack.
    c0 = n_rd;
    wr(2'd0, 16'o101);
    @(negedge i_clk);
    chk("rdr_busy_n1", o_rdata[11], 1);
    chk("rdr_noread_n1", o_tape_read, 0);
    @(negedge i_clk);
    chk("rdr_read_n2", o_tape_read, 1);
    cyc(1);
    i_tape_read_busy = 1'b1;
    cyc(3);
    i_tape_read_busy = 1'b0;
    cyc(1);
    @(negedge i_clk);
    chk("rdr_prs_done", o_rdata, 16'o000300);
    wait_neg(4, 3);
    chk("rdr_irq", o_irq, 1);
    chk("rdr_vec", o_irq_vector, 8'o070);
    chk("rdr_read_count", n_rd - c0, 1);
    cyc(1);
    i_irq_ack = 1'b1;
    cyc(1);
    i_irq_ack = 1'b0;
    @(negedge i_clk);
    chk("rdr_irq_acked", o_irq, 0);

    // PRB read: data, clears done, clear_done held while engine done stays high.
    cyc(1);
    i_tape_read_data = 8'hA5; i_tape_read_done = 1'b1;
    i_reg_sel = 2'd1; i_rd = 1'b1;
    @(negedge i_clk);
    chk("prb_data", o_rdata, 16'h00A5);
    cyc(1);
    i_rd = 1'b0;
    cyc(3);
    @(negedge i_clk);
    chk("prb_clear_held", o_tape_clear_done, 1);
    i_reg_sel = 2'd0;
    #1;
    chk("prb_rdone_clr", o_rdata[7], 0);
    cyc(1);
    i_tape_read_done = 1'b0;
    cyc(1);
    @(negedge i_clk);
    chk("prb_clear_drop", o_tape_clear_done, 0);
    cyc(1);
    wr(2'd0, 16'o000);

    // Punch: latch byte, one pulse, write while busy ignored.
    c0 = n_pu; c1 = n_fl;
    wr(2'd3, 16'h0041);
    @(negedge i_clk);
    chk("ppb_data", o_tape_punch_data, 8'h41);
    wait_neg(6, 1);
    chk("ppb_pulse", o_tape_punch, 1);
    cyc(1);
    i_tape_punch_ready = 1'b0;
    wr(2'd3, 16'h0042);
    cyc(3);
    chk("ppb_busy_ignored", n_pu - c0, 1);
    chk("ppb_data_kept", o_tape_punch_data, 8'h41);
    i_tape_punch_ready = 1'b1;
    cyc(2);
    i_reg_sel = 2'd2;
    @(negedge i_clk);
    chk("pps_ready_back", o_rdata, 16'h0080);

    // Flush request while ready.
    cyc(1);
    wr(2'd2, 16'o001);
    wait_neg(6, 2);
    chk("flush_pulse", o_tape_flush, 1);
    cyc(1);
    i_tape_punch_ready = 1'b0;
    cyc(2);
    i_tape_punch_ready = 1'b1;
    cyc(2);
    chk("flush_count", n_fl - c1, 1);
    chk("flush_no_punch", n_pu - c0, 1);

    // Reader enable while punch busy waits for punch ready.
    wr(2'd3, 16'h0055);
    wait_neg(6, 1);
    cyc(1);
    i_tape_punch_ready = 1'b0;
    c0 = n_rd;
    wr(2'd0, 16'o001);
    cyc(5);
    chk("rdr_wait_noread", n_rd - c0, 0);
    chk("rdr_wait_busy", o_rdata[11], 1);
    i_tape_punch_ready = 1'b1;
    wait_neg(8, 0);
    chk("rdr_after_ready", o_tape_read, 1);
    cyc(1);
    i_tape_read_busy = 1'b1;
    cyc(2);
    i_tape_read_busy = 1'b0;
    cyc(3);
    chk("rdr_wait_done", o_rdata, 16'o000200);
    chk("rdr_wait_count", n_rd - c0, 1);

    // Reset mid-command: no pulse after release.
    c0 = n_rd;
    wr(2'd0, 16'o001);
    do_reset();
    cyc(5);
    chk("rst_mid_noread", n_rd - c0, 0);
    chk("rst_mid_prs", o_rdata, 16'h0000);

    // Timeout: engine busy forever.
    wr(2'd0, 16'o001);
    wait_neg(6, 0);
    cyc(1);
    i_tape_read_busy = 1'b1;
    cnt = 0;
    while (o_rdata[11] && cnt < 300) begin
      cyc(1);
      cnt++;
    end
    chk("tmo_window", (cnt >= 90 && cnt <= 110), 1);
    @(negedge i_clk);
    chk("tmo_prs", o_rdata, 16'o100200);
    i_tape_read_busy = 1'b0;

    // Error + both interrupts: reader has priority.
    do_reset();
    wr(2'd2, 16'o100);
    wait_neg(4, 3);
    chk("pun_irq", o_irq, 1);
    chk("pun_vec", o_irq_vector, 8'o074);
    cyc(1);
    wr(2'd0, 16'o100);
    i_sd_error = 4'd7;
    @(negedge i_clk);
    chk("err_prs", o_rdata, 16'o100100);
    cyc(2);
    @(negedge i_clk);
    chk("both_vec_rdr", o_irq_vector, 8'o070);
    cyc(1);
    i_irq_ack = 1'b1;
    cyc(1);
    i_irq_ack = 1'b0;
    @(negedge i_clk);
    chk("both_vec_pun", o_irq_vector, 8'o074);
    chk("both_irq_pun", o_irq, 1);
    cyc(1);
    i_irq_ack = 1'b1;
    cyc(1);
    i_irq_ack = 1'b0;
    @(negedge i_clk);
    chk("both_acked", o_irq, 0);

    // Randomized register/interrupt traffic against a behavioural model (engines idle).
    do_reset();
    m_rie = 0; m_pie = 0; m_rp = 0; m_pp = 0; m_rl = 0; m_pl = 0;
    for (int i = 0; i < 300; i++) begin
      i_reg_sel = 2'($urandom_range(0, 3));
      i_wr = 1'b0; i_rd = 1'b0;
      case ($urandom_range(0, 3))
        0: begin i_wr = 1'b1; i_reg_sel = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2; end
        1: i_rd = 1'b1;
        default: ;
      endcase
      i_wdata = 16'($urandom) & 16'hFFFE;
      i_sd_error = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      i_tape_punch_ready = ($urandom_range(0, 2) != 0);
      i_tape_read_data = 8'($urandom);
      i_irq_ack = ($urandom_range(0, 3) == 0);
      @(negedge i_clk);
      e = (i_sd_error != 0);
      case (i_reg_sel)
        2'd0: exp_rd = (e ? 16'h8000 : 16'h0) | (m_rie ? 16'h0040 : 16'h0);
        2'd1: exp_rd = {8'h00, i_tape_read_data};
        2'd2: exp_rd = (e ? 16'h8000 : 16'h0) | (i_tape_punch_ready ? 16'h0080 : 16'h0)
                     | (m_pie ? 16'h0040 : 16'h0);
        default: exp_rd = 16'h0000;
      endcase
      exp_vec = m_rp ? 8'o070 : (m_pp ? 8'o074 : 8'o070);
      chk("rnd_rdata", o_rdata, exp_rd);
      chk("rnd_irq", o_irq, m_rp | m_pp);
      chk("rnd_vec", o_irq_vector, exp_vec);
      @(posedge i_clk);
      rl = e & m_rie;
      pl = i_tape_punch_ready & m_pie;
      ar = i_irq_ack & m_rp;
      ap = i_irq_ack & !m_rp & m_pp;
      if (rl && !m_rl) m_rp = 1; else if (ar || !rl) m_rp = 0;
      if (pl && !m_pl) m_pp = 1; else if (ap || !pl) m_pp = 0;
      m_rl = rl; m_pl = pl;
      if (i_wr && i_reg_sel == 2'd0) m_rie = i_wdata[6];
      if (i_wr && i_reg_sel == 2'd2) m_pie = i_wdata[6];
      #1;
    end
    i_wr = 1'b0; i_rd = 1'b0; i_irq_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc11_regs.md
# pc11_regs

PDP-11 PC11-compatible paper-tape register block for the DC-J11 memory/IO side. It decodes CPU accesses to PRS/PRB/PPS/PPB (777550–777556) and issues single-cycle read/punch/flush commands to the SD tape engine. It tracks reader DONE/BUSY and punch READY locally and raises vectored interrupts (reader 070, punch 074). It sits directly upstream of the SD tape engine and consumes its busy/done/ready/data/error outputs.

## Interface
- TIMEOUT_CYC, 27_000_000 — cycles before an SD command is declared lost (1 s at 27 MHz).
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_reg_sel  in  2  0=PRS, 1=PRB, 2=PPS, 3=PPB (address bits [2:1]).
- i_rd, i_wr  in  1  one-cycle access strobes; mutually exclusive.
- i_wdata  in  16  write data.
- o_rdata  out  16  read data, combinational from i_reg_sel.
- o_irq  out  1  interrupt request.
- o_irq_vector  out  8  8'o070 or 8'o074.
- i_irq_ack  in  1  one-cycle grant of the presented vector.
- o_tape_read, o_tape_punch, o_tape_flush  out  1  one-cycle command pulses.
- o_tape_clear_done  out  1  level, clear request to engine.
- o_tape_punch_data  out  8  latched PPB byte.
- i_tape_read_busy, i_tape_read_done, i_tape_punch_ready  in  1  engine status.
- i_tape_read_data  in  8  engine PRBUF.
- i_sd_error  in  4  engine error code; nonzero = card fault.

## Operation
- PRS read: {err,3'b0,rbusy,3'b0,rdone,rie,6'b0}. PRB read: {8'h00,i_tape_read_data}. PPS read: {err,7'b0,pready,pie,6'b0}. PPB read: 0. err = (i_sd_error!=0)|tmo.
- PRS write: rie<=wdata[6]; wdata[0]=1 (RDR ENB) clears rdone, clears tmo, starts reader FSM if R_IDLE (ignored otherwise).
- PRB read: clears rdone; sets o_tape_clear_done until i_tape_read_done==0.
- PPS write: pie<=wdata[6]; wdata[0]=1 requests flush when pready (ignored otherwise).
- PPB write when pready: latch wdata[7:0], clear tmo, start punch FSM; ignored when not pready.
- Reader FSM: R_IDLE → R_WAIT (on RDR ENB) → R_PULSE when i_tape_punch_ready & P_IDLE (o_tape_read=1 for that cycle) → R_BUSY → R_IDLE when i_tape_read_busy==0 after having been seen 1; rdone<=1 on exit. rbusy = state≠R_IDLE.
- Punch FSM: P_IDLE → P_WAIT → P_PULSE (o_tape_punch or o_tape_flush) → P_BUSY → P_IDLE as reader. pready = P_IDLE & i_tape_punch_ready & R_IDLE.
- Timeout: shared counter, cleared on entry to *_WAIT; at TIMEOUT_CYC in WAIT/BUSY: tmo<=1, FSM→IDLE, rdone<=1 if reader.
- Interrupts: rpend set on rising edge of (rdone|err)&rie; ppend on rising edge of pready&pie. Cleared by i_irq_ack for presented source, or when the level drops. Reader has priority. o_irq=rpend|ppend.

## Timing
- Reset values: o_rdata per state (PRS=0 unless i_sd_error≠0, PPS bit7 follows engine), o_irq=0, o_irq_vector=8'o070, all pulses 0, o_tape_clear_done=0, o_tape_punch_data=0; rie=pie=rdone=tmo=0; FSMs IDLE.
- RDR ENB write in cycle N with engine idle: o_tape_read in N+2; rbusy reads 1 from N+1.
- Write/read side effects commit on the strobe edge; o_rdata for the same cycle shows pre-update value.
- Ack coincident with new rising edge of the same source: set wins.
- Reset mid-command abandons FSMs; no pulse is emitted after reset release until a new command.
- RDR ENB and PPB write never coexist (one strobe/cycle); reader waiting behind punch waits in R_WAIT.

## Structure
- Package pc11_pkg: register select codes, bit positions (ERR=15, BUSY=11, DONE/READY=7, IE=6, ENB=0), vectors 8'o070/8'o074, FSM state enums.
- One sub-module natural: pc11_irq_edge (rising-edge pending flag with ack), instantiated twice.

## Test plan
- RDR ENB (PRS<=16'o101) with engine idle → o_tape_read one cycle; busy 1→0 then PRS=16'o000300, o_irq=1, vector 070; ack → o_irq=0.
- PRB read returning 8'hA5 → o_rdata=16'h00A5, rdone cleared, o_tape_clear_done held until engine done=0.
- PPB<=16'h0041 when ready → o_tape_punch_data=8'h41, one o_tape_punch; second PPB write while busy ignored (no pulse).
- RDR ENB issued while punch busy → o_tape_read only after i_tape_punch_ready returns 1.
- Engine never drops busy, TIMEOUT_CYC=100 → after 100 cycles PRS bit15 and bit7 set, FSM idle.
- i_sd_error=7 with rie=1 → PRS bit15=1 and reader interrupt raised; both irqs pending → 070 first, then 074 after ack.
